shift_xfer: RTL and testbench

- Multi-lane, full-duplex shift engine with a runtime-programmable transfer length.
- It is the next generation of the team's single-direction shift counter.
- Transmits left-aligned tx_data over 1, 2 or 4 lanes and shifts received lane bits into the same register.
- Sits between the SPI controller FSM (supplies start/se on SCK edges) and the cache fill/command datapath; serves x1/x2/x4 SPI flash/PSRAM.

---
 rtl/shift_xfer_pkg.sv | 28 ++
 rtl/shift_xfer.sv | 159 +++++++++++++++
 tb/tb_shift_xfer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/shift_xfer_pkg.sv
// Shared types and helpers for the shift_xfer multi-lane shift engine.
package shift_xfer_pkg;

   typedef enum logic [1:0] {
      LANE_X1   = 2'd0,
      LANE_X2   = 2'd1,
      LANE_X4   = 2'd2,
      LANE_RSVD = 2'd3
   } lane_mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Bits moved per shift step for a lane mode, clamped to the physical lane count.
   // The reserved mode behaves as single-lane.
   function automatic int lane_step(input lane_mode_e mode, input int max_lanes);
      int s;
      case (mode)
         LANE_X2: s = 2;
         LANE_X4: s = 4;
         default: s = 1;
      endcase
      return (s > max_lanes) ? max_lanes : s;
   endfunction

endpackage

// File: rtl/shift_xfer.sv
// shift_xfer: full-duplex 1/2/4-lane shift engine with programmable length.
// Transmit data leaves from the register top while received lane bits enter
// at the bottom, so rx_data ends up holding the received word right-aligned.
// Optional build macro SHIFT_XFER_LSB_FIRST_EN adds a lsb_first input that
// reverses the shift direction (transmit from bit 0, receive into the top).
module shift_xfer
   import shift_xfer_pkg::*;
#(
   parameter  int SIZE      = 32,
   parameter  int MAX_LANES = 4,
   localparam int CNT_W     = $clog2(SIZE + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [SIZE-1:0]      tx_data,
   input  logic [CNT_W-1:0]     len,
   input  logic [1:0]           mode,
`ifdef SHIFT_XFER_LSB_FIRST_EN
   input  logic                 lsb_first,
`endif
   input  logic                 se,
   input  logic [MAX_LANES-1:0] rx_lanes,
   output logic [MAX_LANES-1:0] dout,
   output logic [SIZE-1:0]      rx_data,
   output logic                 busy,
   output logic                 done,
   output logic                 lst_cycle
);

   localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

   state_e               state_q, state_d;
   logic [SIZE-1:0]      reg_q, reg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     step_q, step_d;
   logic                 lsb_q, lsb_d;
   logic                 done_q, done_d;

   logic [CNT_W-1:0]     step_in_s;
   logic [CNT_W-1:0]     len_min_s;
   logic [CNT_W-1:0]     len_eff_s;
   logic                 lsb_in_s;
   logic [MAX_LANES-1:0] lane_mask_s;
   logic [SIZE-1:0]      rx_ext_s;
   logic [SIZE-1:0]      shift_msb_s;
   logic [SIZE-1:0]      shift_lsb_s;
   logic [SIZE-1:0]      top_s;

`ifdef SHIFT_XFER_LSB_FIRST_EN
   assign lsb_in_s = lsb_first;
`else
   assign lsb_in_s = 1'b0;
`endif

   // Requested step and effective length: clamp to SIZE, round down to a step multiple.
   assign step_in_s = CNT_W'(lane_step(lane_mode_e'(mode), MAX_LANES));
   assign len_min_s = (len > SIZE_C) ? SIZE_C : len;
   assign len_eff_s = len_min_s & ~(step_in_s - CNT_W'(1));

   // Active-lane mask for the latched step; unused lanes are forced to zero.
   always_comb begin
      lane_mask_s = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         lane_mask_s[i] = (CNT_W'(i) < step_q);
      end
   end

   // Shifted register images for both directions; rx_lanes[step-1] lands highest.
   assign rx_ext_s    = SIZE'(rx_lanes & lane_mask_s);
   assign shift_msb_s = (reg_q << step_q) | rx_ext_s;
   assign shift_lsb_s = (reg_q >> step_q) | (rx_ext_s << (SIZE_C - step_q));
   assign top_s       = reg_q >> (SIZE_C - step_q);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a non-empty start enters SHIFT, the final step returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start && (len_eff_s != '0)) state_d = ST_SHIFT;
            else                            state_d = ST_IDLE;
         end
         ST_SHIFT: begin
            if (se && (cnt_q == step_q)) state_d = ST_IDLE;
            else                         state_d = ST_SHIFT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: load on idle start, shift and count down on se while busy.
   always_comb begin
      reg_d  = reg_q;
      cnt_d  = cnt_q;
      step_d = step_q;
      lsb_d  = lsb_q;
      done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               reg_d  = tx_data;
               cnt_d  = len_eff_s;
               step_d = step_in_s;
               lsb_d  = lsb_in_s;
               done_d = (len_eff_s == '0);
            end else begin
               done_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (se) begin
               reg_d  = lsb_q ? shift_lsb_s : shift_msb_s;
               cnt_d  = cnt_q - step_q;
               done_d = (cnt_q == step_q);
            end else begin
               done_d = 1'b0;
            end
         end
         default: done_d = 1'b0;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_q  <= '0;
         cnt_q  <= '0;
         step_q <= '0;
         lsb_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         reg_q  <= reg_d;
         cnt_q  <= cnt_d;
         step_q <= step_d;
         lsb_q  <= lsb_d;
         done_q <= done_d;
      end
   end

   // Outputs: status flags and the lane mux off the register edge being shifted out.
   always_comb begin
      busy      = (state_q == ST_SHIFT);
      lst_cycle = (state_q == ST_SHIFT) && (cnt_q == step_q);
      done      = done_q;
      rx_data   = reg_q;
      if (lsb_q) dout = reg_q[MAX_LANES-1:0] & lane_mask_s;
      else       dout = top_s[MAX_LANES-1:0] & lane_mask_s;
   end

endmodule

// File: tb/tb_shift_xfer.sv
// Self-checking bench for shift_xfer (default MSB-first build, SIZE=32, 4 lanes).
module tb_shift_xfer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] tx_data;
   logic [5:0]  len;
   logic [1:0]  mode;
   logic        se;
   logic [3:0]  rx_lanes;
   logic [3:0]  dout;
   logic [31:0] rx_data;
   logic        busy;
   logic        done;
   logic        lst_cycle;

   int          vectors    = 0;
   int          miscompares = 0;
   int          rx_dir [0:31];
   logic [31:0] last_exp;

   shift_xfer #(.SIZE(32), .MAX_LANES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .tx_data   (tx_data),
      .len       (len),
      .mode      (mode),
`ifdef SHIFT_XFER_LSB_FIRST_EN
      .lsb_first (1'b0),
`endif
      .se        (se),
      .rx_lanes  (rx_lanes),
      .dout      (dout),
      .rx_data   (rx_data),
      .busy      (busy),
      .done      (done),
      .lst_cycle (lst_cycle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transfer, starting and ending at a falling edge. gap_at >= 0 inserts a
   // 5-cycle se gap before that step, with a stray start pulse in its first cycle.
   task automatic do_xfer(input logic [31:0] tx, input int ln, input int md,
                          input bit use_dir, input int gap_at);
      int          stp, le, n;
      logic [63:0] tx64, acc, rxv, msk, expv;
      stp  = (md == 1) ? 2 : (md == 2) ? 4 : 1;
      le   = (ln > 32) ? 32 : ln;
      le   = (le / stp) * stp;
      n    = le / stp;
      msk  = (64'd1 << stp) - 64'd1;
      tx64 = {32'h0, tx};
      acc  = 64'd0;
      start = 1'b1; tx_data = tx; len = 6'(ln); mode = 2'(md);
      @(posedge clk); @(negedge clk);
      start = 1'b0; tx_data = $urandom;
      if (n == 0) begin
         chk("zero_len_done", {63'd0, done}, 64'd1);
         chk("zero_len_busy", {63'd0, busy}, 64'd0);
         chk("zero_len_reg", {32'd0, rx_data}, tx64);
         @(posedge clk); @(negedge clk);
         chk("zero_len_done_clr", {63'd0, done}, 64'd0);
         chk("zero_len_busy_hold", {63'd0, busy}, 64'd0);
         last_exp = tx;
         return;
      end
      for (int k = 0; k < n; k++) begin
         if (k == gap_at) begin
            for (int g = 0; g < 5; g++) begin
               se = 1'b0; start = (g == 0); tx_data = ~tx; rx_lanes = 4'($urandom);
               @(posedge clk); @(negedge clk);
               start = 1'b0;
               expv = ((tx64 << (stp * k)) | acc) & 64'hFFFF_FFFF;
               chk("gap_busy", {63'd0, busy}, 64'd1);
               chk("gap_reg", {32'd0, rx_data}, expv);
               chk("gap_lst", {63'd0, lst_cycle}, {63'd0, (k == n - 1)});
            end
         end
         rxv = use_dir ? 64'(rx_dir[k]) : 64'($urandom_range(0, 15));
         chk("dout", {60'd0, dout}, (tx64 >> (32 - stp * (k + 1))) & msk);
         chk("lst_cycle", {63'd0, lst_cycle}, {63'd0, (k == n - 1)});
         chk("busy", {63'd0, busy}, 64'd1);
         chk("done_low", {63'd0, done}, 64'd0);
         se = 1'b1; rx_lanes = rxv[3:0];
         @(posedge clk); @(negedge clk);
         se = 1'b0;
         acc = (acc << stp) | (rxv & msk);
      end
      expv = ((tx64 << le) | acc) & 64'hFFFF_FFFF;
      last_exp = expv[31:0];
      chk("end_done", {63'd0, done}, 64'd1);
      chk("end_busy", {63'd0, busy}, 64'd0);
      chk("end_lst", {63'd0, lst_cycle}, 64'd0);
      chk("end_rx_data", {32'd0, rx_data}, expv);
      @(posedge clk); @(negedge clk);
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("rx_data_hold", {32'd0, rx_data}, expv);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; tx_data = 32'h0; len = 6'd0; mode = 2'd0;
      se = 1'b0; rx_lanes = 4'h0;
      #3;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_dout", {60'd0, dout}, 64'd0);
      chk("rst_rx_data", {32'd0, rx_data}, 64'd0);
      chk("rst_lst", {63'd0, lst_cycle}, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      // x1, len 8, rx 1,1,0,0,1,1,0,0 -> rx_data[7:0] = CC
      rx_dir[0] = 1; rx_dir[1] = 1; rx_dir[2] = 0; rx_dir[3] = 0;
      rx_dir[4] = 1; rx_dir[5] = 1; rx_dir[6] = 0; rx_dir[7] = 0;
      do_xfer(32'hA500_0000, 8, 0, 1'b1, -1);
      chk("x1_low_byte", {56'd0, last_exp[7:0]}, 64'hCC);

      // x4, len 16, rx nibbles F,0,0,D -> rx_data[15:0] = F00D
      rx_dir[0] = 15; rx_dir[1] = 0; rx_dir[2] = 0; rx_dir[3] = 13;
      do_xfer(32'h1234_0000, 16, 2, 1'b1, -1);
      chk("x4_low_half", {48'd0, last_exp[15:0]}, 64'hF00D);

      // x2, len 7 -> 3 steps, then se while idle must not disturb rx_data
      do_xfer($urandom, 7, 1, 1'b0, -1);
      for (int i = 0; i < 3; i++) begin
         se = 1'b1; rx_lanes = 4'($urandom);
         @(posedge clk); @(negedge clk);
         chk("idle_se_rx_data", {32'd0, rx_data}, {32'd0, last_exp});
         chk("idle_se_busy", {63'd0, busy}, 64'd0);
      end
      se = 1'b0;

      // zero length
      do_xfer(32'hDEAD_BEEF, 0, 0, 1'b0, -1);

      // mid-transfer se gap plus stray start
      do_xfer($urandom, 8, 0, 1'b0, 3);
      do_xfer($urandom, 32, 2, 1'b0, 2);

      // async reset between edges after 3 of 8 shifts
      start = 1'b1; tx_data = 32'hFFFF_FFFF; len = 6'd8; mode = 2'd0;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         se = 1'b1; rx_lanes = 4'hF;
         @(posedge clk); @(negedge clk);
      end
      se = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_dout", {60'd0, dout}, 64'd0);
      chk("arst_rx_data", {32'd0, rx_data}, 64'd0);
      chk("arst_lst", {63'd0, lst_cycle}, 64'd0);
      chk("arst_done", {63'd0, done}, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      do_xfer($urandom, 8, 0, 1'b0, -1);

      // randomized transfers across all modes and lengths (including > SIZE)
      for (int t = 0; t < 30; t++) begin
         do_xfer($urandom, $urandom_range(0, 40), $urandom_range(0, 3), 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1 : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
